// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller.
// Holds the access-size encodings, the controller FSM state encoding, the
// default geometry and the combinational lane helpers (alignment check,
// load extraction, store merge) that the controller uses.
package mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // Reserved size, odd halfword and non-word-aligned word accesses are errors.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed little-endian lane(s) and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of old with right-justified wd.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the ALU-side requester and data_mem_ctrl.
// master: drives req, we, size, sign_ext, addr, wdata; sees ready, done,
//         rdata, misalign.
// slave : the controller side, directions mirrored.
interface data_mem_ctrl_if import mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic [31:0]       rdata;
  logic              misalign;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, done, rdata, misalign
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, done, rdata, misalign
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 data RAM.
// Ports: clk; en (access enable); we (1 = write); addr (word index);
// wdata (write data); rdata (registered read data, one-cycle latency).
// The read register only changes on a read, so a value fetched for a
// read-modify-write stays stable through the following write cycle.
// No reset: contents survive controller resets.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Synchronous write or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one byte/halfword/word load or store per
// request, checks alignment, and runs the access against dmem_ram.
// Ports: clk (rising edge); reset (async, active low); bus (slave side of
// data_mem_ctrl_if: req/we/size/sign_ext/addr/wdata in, ready/done/rdata/
// misalign out).
// Paths: error IDLE->RESP; load IDLE->RD->RESP; word store IDLE->WR->RESP;
// sub-word store IDLE->RD->WR->RESP (read-modify-write).
module data_mem_ctrl import mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              acc_err;
  logic              load_ok;
  logic [31:0]       load_val;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  assign accept   = (state_q == ST_IDLE) && bus.req;
  assign acc_err  = access_misaligned(bus.size, bus.addr[1:0]);
  assign load_ok  = !we_q && !err_q;
  assign load_val = load_extract(ram_rdata, size_q, addr_q[1:0], sext_q);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (acc_err) begin
          state_d = ST_RESP;
        end else if (bus.we && (bus.size == SZ_WORD)) begin
          state_d = ST_WR;
        end else begin
          // loads, and sub-word stores that need the old word first
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (we_q) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture registers and held load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next values of the capture registers and the held load result.
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      we_d    = bus.we;
      size_d  = bus.size;
      sext_d  = bus.sign_ext;
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
      err_d   = acc_err;
    end else begin
      we_d    = we_q;
    end
    if ((state_q == ST_RESP) && load_ok) begin
      rdata_d = load_val;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FSM outputs and RAM control.
  always_comb begin
    bus.ready    = (state_q == ST_IDLE);
    bus.done     = (state_q == ST_RESP);
    bus.misalign = (state_q == ST_RESP) && err_q;
    // The RAM result is only ready in RESP, so a successful load is shown
    // directly there and latched into rdata_q for the following cycles.
    if ((state_q == ST_RESP) && load_ok) begin
      bus.rdata = load_val;
    end else begin
      bus.rdata = rdata_q;
    end
    ram_en    = (state_q == ST_RD) || (state_q == ST_WR);
    ram_we    = (state_q == ST_WR);
    // Index truncation gives the modulo-DEPTH wrap.
    ram_addr  = RAM_AW'(addr_q[ADDR_W-1:2]);
    // A word store merges to wdata unchanged, so one path serves both.
    ram_wdata = store_merge(ram_rdata, wdata_q, size_q, addr_q[1:0]);
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus random traffic
// against a word-array model of the RAM using shift/mask lane arithmetic.
module tb_data_mem_ctrl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] model_mem [256];
  logic [31:0] last_rd;

  data_mem_ctrl_if #(.ADDR_W(10)) bus ();

  data_mem_ctrl #(.ADDR_W(10), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic mdl_err(input logic [1:0] sz, input logic [9:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mdl_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'h0000_00FF;
    if (sz == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sx);
    int          sh;
    logic [31:0] m;
    logic [31:0] v;
    sh = 8 * int'(off);
    m  = mdl_mask(sz);
    v  = (word >> sh) & m;
    if (sz != 2'd2 && sx && ((v & ((m >> 1) + 32'd1)) != 32'd0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] off);
    int          sh;
    logic [31:0] m;
    sh = 8 * int'(off);
    m  = mdl_mask(sz);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // One complete access: drive, time the done pulse, compare outputs.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [9:0] a, input logic [31:0] wd);
    logic err;
    int   exp_lat;
    int   idx;
    int   k;
    logic got_done;
    idx = int'(a[9:2]);
    err = mdl_err(sz, a);
    if (err)                exp_lat = 1;
    else if (!w)            exp_lat = 2;
    else if (sz == 2'd2)    exp_lat = 2;
    else                    exp_lat = 3;
    if (!err && !w) last_rd = mdl_load(model_mem[idx], sz, a[1:0], sx);
    if (!err && w)  model_mem[idx] = mdl_store(model_mem[idx], wd, sz, a[1:0]);

    @(negedge clk);
    check("ready_before", {31'd0, bus.ready}, 32'd1);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1 bus.req = 1'b0;
    k = 0;
    got_done = 1'b0;
    while (!got_done && k < 6) begin
      @(negedge clk);
      k++;
      got_done = bus.done;
    end
    check("latency", k, exp_lat);
    check("misalign", {31'd0, bus.misalign}, {31'd0, err});
    check("rdata", bus.rdata, last_rd);
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd0);
    check("rdata_hold", bus.rdata, last_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    n_checks = 0;
    n_errors = 0;
    last_rd  = 32'd0;
    reset_n  = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 10'd0; bus.wdata = 32'd0;
    #23;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill every word so the model matches the RAM, top index included.
    for (int i = 0; i < 256; i++) begin
      rv = $urandom;
      access(1'b1, 2'd2, 1'b0, 10'(i * 4), rv);
    end

    // Word store then load.
    access(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEAD_BEEF);
    access(1'b0, 2'd2, 1'b0, 10'h010, 32'd0);
    check("req034", bus.rdata, 32'hDEAD_BEEF);
    // Byte store read-modify-write, word/byte loads with both extensions.
    access(1'b1, 2'd0, 1'b0, 10'h012, 32'h0000_00AA);
    access(1'b0, 2'd2, 1'b0, 10'h010, 32'd0);
    check("req035_word", bus.rdata, 32'hDEAA_BEEF);
    access(1'b0, 2'd0, 1'b1, 10'h012, 32'd0);
    check("req035_sext", bus.rdata, 32'hFFFF_FFAA);
    access(1'b0, 2'd0, 1'b0, 10'h012, 32'd0);
    check("req035_zext", bus.rdata, 32'h0000_00AA);
    // Misaligned halfword, reserved size (load and store), RAM unchanged.
    access(1'b0, 2'd1, 1'b0, 10'h011, 32'd0);
    access(1'b0, 2'd3, 1'b0, 10'h010, 32'd0);
    access(1'b1, 2'd3, 1'b0, 10'h010, 32'h1234_5678);
    check("req036_rdata", bus.rdata, 32'h0000_00AA);
    access(1'b0, 2'd2, 1'b0, 10'h010, 32'd0);
    check("req036_ram", bus.rdata, 32'hDEAA_BEEF);
    // Highest word index.
    access(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hCAFE_F00D);
    access(1'b0, 2'd2, 1'b0, 10'h3FC, 32'd0);
    check("req037", bus.rdata, 32'hCAFE_F00D);

    // Reset in the RD cycle of a byte store must abort it.
    access(1'b1, 2'd2, 1'b0, 10'h020, 32'h1122_3344);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = 10'h020; bus.wdata = 32'h0000_00EE;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    last_rd = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", {31'd0, bus.done}, 32'd0);
    access(1'b0, 2'd2, 1'b0, 10'h020, 32'd0);
    check("req038", bus.rdata, 32'h1122_3344);

    // req held high across two loads: second accepted after RESP only.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.sign_ext = 1'b0;
    bus.addr = 10'h040;
    @(posedge clk);
    @(negedge clk);                       // RD of first load
    bus.addr = 10'h080;
    check("b2b_busy1", {31'd0, bus.done}, 32'd0);
    @(negedge clk);                       // RESP of first load
    check("b2b_done1", {31'd0, bus.done}, 32'd1);
    check("b2b_rd1", bus.rdata, model_mem[16]);
    @(negedge clk);                       // IDLE, second accepted at next edge
    check("b2b_gap", {31'd0, bus.done}, 32'd0);
    check("b2b_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);                       // RD of second load
    bus.req = 1'b0;
    check("b2b_busy2", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check("b2b_done2", {31'd0, bus.done}, 32'd1);
    check("b2b_rd2", bus.rdata, model_mem[32]);
    last_rd = model_mem[32];
    @(negedge clk);
    check("b2b_end", {31'd0, bus.done}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 1023)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
